// File: rtl/latency_pipe_sched_pkg.sv
// Shared types and helpers for the latency pipe sequencing controller.
// Holds the FSM state encoding, the latency-width rule and lane slicing.
package latency_pipe_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // One bit is still needed for a single-stage bank.
  function automatic int lat_width(input int max_stage);
    return (max_stage > 1) ? $clog2(max_stage + 1) : 1;
  endfunction

  // LSB of lane 'lane' inside a packed cfg_lat / lat_o vector.
  function automatic int lane_lsb(input int lane, input int lat_w);
    return lane * lat_w;
  endfunction

endpackage

// File: rtl/latency_pipe_sched_tracker.sv
// Valid shift register mirroring the pipes, with one tap mux per lane.
// Tap 0 is the issue strobe itself, so zero-latency lanes are combinational.
module pipe_vld_tracker
  import latency_pipe_sched_pkg::*;
#(
  parameter int NUM_LANES      = 4,
  parameter int MAX_PIPE_STAGE = 4,
  parameter int LAT_W          = lat_width(MAX_PIPE_STAGE)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       in_vld,
  input  logic [NUM_LANES*LAT_W-1:0] lat,
  output logic [NUM_LANES-1:0]       lane_vld
);

  logic [MAX_PIPE_STAGE-1:0] trk_reg;
  logic [MAX_PIPE_STAGE:0]   tap;

  assign tap = {trk_reg, in_vld};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_reg <= '0;
    end else if (clr) begin
      trk_reg <= '0;
    end else begin
      trk_reg <= tap[MAX_PIPE_STAGE-1:0];
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [LAT_W-1:0] lane_lat;
      assign lane_lat     = lat[lane_lsb(gi, LAT_W) +: LAT_W];
      assign lane_vld[gi] = tap[lane_lat];
    end
  endgenerate

endmodule

// File: rtl/latency_pipe_sched.sv
// Sequencing controller for a bank of variable-latency pipes: config capture
// with clamping, drain-before-reconfigure FSM, issue gating and valid strobes.
module latency_pipe_sched
  import latency_pipe_sched_pkg::*;
#(
  parameter int  NUM_PIPES      = 4,
  parameter int  MAX_PIPE_STAGE = 4,
  localparam int LAT_W          = lat_width(MAX_PIPE_STAGE)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [NUM_PIPES*LAT_W-1:0] cfg_lat,
  output logic                       cfg_err,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  output logic [NUM_PIPES*LAT_W-1:0] lat_o,
  output logic                       clr_o,
  output logic [NUM_PIPES-1:0]       lane_vld,
  output logic                       out_valid,
  output logic                       busy
);

  localparam logic [LAT_W-1:0] MAX_LAT = LAT_W'(MAX_PIPE_STAGE);

  state_e                     state_reg, state_next;
  logic [NUM_PIPES*LAT_W-1:0] lat_reg, lat_clamp;
  logic [NUM_PIPES-1:0]       clamp_hit;
  logic [LAT_W-1:0]           lat_max_reg, lat_max_next;
  logic [LAT_W-1:0]           inflight_reg, inflight_next;
  logic                       cfg_err_reg;
  logic                       cfg_fire, issue_fire;
  logic [NUM_PIPES:0]         tap_vld;

  assign cfg_ready  = (state_reg == IDLE) || ((state_reg == DRAIN) && (inflight_reg == '0));
  assign cfg_fire   = cfg_valid && cfg_ready && !flush;
  assign issue_fire = issue_valid && issue_ready;

  generate
    for (genvar gi = 0; gi < NUM_PIPES; gi++) begin : g_clamp
      logic [LAT_W-1:0] raw;
      assign raw           = cfg_lat[lane_lsb(gi, LAT_W) +: LAT_W];
      assign clamp_hit[gi] = (raw > MAX_LAT);
      assign lat_clamp[lane_lsb(gi, LAT_W) +: LAT_W] = clamp_hit[gi] ? MAX_LAT : raw;
    end
  endgenerate

  always_comb begin
    lat_max_next = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (lat_clamp[i*LAT_W +: LAT_W] > lat_max_next) begin
        lat_max_next = lat_clamp[i*LAT_W +: LAT_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    issue_ready = (state_reg == RUN) && !cfg_valid;
    clr_o       = (state_reg == CLR) || flush;
    case (state_reg)
      IDLE:    if (cfg_fire) state_next = CLR;
      CLR:     state_next = RUN;
      RUN:     if (cfg_valid) state_next = DRAIN;
      DRAIN:   if (cfg_fire) state_next = CLR;
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
    end
  end

  // Latencies and error flag survive a flush; only a new handshake replaces them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_reg     <= '0;
      lat_max_reg <= '0;
      cfg_err_reg <= 1'b0;
    end else if (cfg_fire) begin
      lat_reg     <= lat_clamp;
      lat_max_reg <= lat_max_next;
      cfg_err_reg <= |clamp_hit;
    end
  end

  // Zero-latency banks never hold a token across a clock edge.
  always_comb begin
    inflight_next = inflight_reg;
    if (lat_max_reg != '0) begin
      if (issue_fire && !out_valid) begin
        inflight_next = inflight_reg + LAT_W'(1);
      end else if (!issue_fire && out_valid) begin
        inflight_next = inflight_reg - LAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_reg <= '0;
    end else if (clr_o) begin
      inflight_reg <= '0;
    end else begin
      inflight_reg <= inflight_next;
    end
  end

  // The extra top lane taps at lat_max and produces the aggregate strobe.
  pipe_vld_tracker #(
    .NUM_LANES      (NUM_PIPES + 1),
    .MAX_PIPE_STAGE (MAX_PIPE_STAGE),
    .LAT_W          (LAT_W)
  ) u_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr_o),
    .in_vld   (issue_fire),
    .lat      ({lat_max_reg, lat_reg}),
    .lane_vld (tap_vld)
  );

  assign lane_vld  = tap_vld[NUM_PIPES-1:0];
  assign out_valid = tap_vld[NUM_PIPES];
  assign lat_o     = lat_reg;
  assign cfg_err   = cfg_err_reg;
  assign busy      = (state_reg != IDLE) || (inflight_reg != '0);

endmodule

// File: doc/latency_pipe_sched.md
# latency_pipe_sched

Sequencing controller for a bank of NUM_PIPES variable-latency pipes in the CGRA subsystem. Accepts per-lane latency configuration words and applies them to the pipes only after in-flight data has drained. Pulses the pipes' synchronous clear on every reconfiguration. Gates upstream issue and produces per-lane and aggregate output-valid strobes aligned to each lane's configured latency.

## Interface
Parameters:
- NUM_PIPES, 4, number of controlled pipe lanes
- MAX_PIPE_STAGE, 4, deepest latency any lane supports
- LAT_W, derived: $clog2(MAX_PIPE_STAGE+1) if MAX_PIPE_STAGE>1, else 1

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous abort; returns the block to IDLE
- cfg_valid  in  1  new configuration offered
- cfg_ready  out  1  configuration accepted when cfg_valid && cfg_ready
- cfg_lat  in  NUM_PIPES*LAT_W  lane i latency in bits [i*LAT_W +: LAT_W]
- cfg_err  out  1  sticky flag: last accepted config had a clamped lane
- issue_valid  in  1  upstream has a token
- issue_ready  out  1  token accepted when issue_valid && issue_ready
- lat_o  out  NUM_PIPES*LAT_W  latency driven to each pipe
- clr_o  out  1  synchronous clear to all pipes
- lane_vld  out  NUM_PIPES  lane i output of the pipe is valid this cycle
- out_valid  out  1  token leaves the longest lane
- busy  out  1  state != IDLE or inflight != 0

## Operation
- States:
  - IDLE: no config held.
  - CLR: one cycle, clr_o=1.
  - RUN: issuing.
  - DRAIN: waiting for in-flight tokens to retire before accepting a new config.
- Transitions:
  - IDLE: on a cfg handshake, go to CLR.
  - CLR: always go to RUN.
  - RUN: if cfg_valid, go to DRAIN.
  - DRAIN: on a cfg handshake, go to CLR.
  - Any state: flush forces IDLE, overriding every other transition.
- cfg_ready = (state==IDLE) || (state==DRAIN && inflight==0).
- On a cfg handshake:
  - Register cfg_lat into lat_o.
  - Any lane value > MAX_PIPE_STAGE is clamped to MAX_PIPE_STAGE.
  - cfg_err is set if any lane was clamped, otherwise cleared.
  - lat_max = max over lanes, registered along with lat_o.
- issue_ready = (state==RUN) && !cfg_valid. A pending cfg blocks issue in the same cycle.
- issue_fire = issue_valid && issue_ready.
- Valid tracker, MAX_PIPE_STAGE bits:
  - trk[0] <= issue_fire; trk[k] <= trk[k-1].
  - Cleared on CLR, flush and reset.
- Lane taps:
  - lane_vld[i] = (lat_i==0) ? issue_fire : trk[lat_i-1].
  - out_valid = lane tap at lat_max.
- inflight counter, LAT_W bits:
  - +1 on issue_fire when lat_max != 0; −1 on out_valid when lat_max != 0.
  - Both in the same cycle leaves it unchanged.
  - Never exceeds lat_max; underflow is impossible by construction.
- No downstream backpressure exists. The pipes have no enable, so every issued token exits exactly lat cycles later.
- flush:
  - clr_o=1 that cycle, tracker and inflight zeroed, state=IDLE.
  - lat_o and cfg_err retained.

## Timing
- Reset values: state IDLE, lat_o=0, clr_o=0, cfg_err=0, issue_ready=0, lane_vld=0, out_valid=0, busy=0, tracker and inflight 0. cfg_ready=1 out of reset.
- Config handshake at cycle t:
  - clr_o=1 and new lat_o visible at t+1 (CLR).
  - First issue_ready at t+2.
- Token issued at cycle t:
  - lane_vld[i] at t+lat_i.
  - Lanes with latency 0 assert combinationally in cycle t.
- DRAIN entered at t with k tokens in flight: cfg_ready rises at t+k at the latest, and exactly when the last out_valid has retired.
- lat_max=0: DRAIN is immediate. cfg_ready is asserted in the first DRAIN cycle.
- Reset asserted mid-operation: all state clears asynchronously. In-flight tokens are discarded and never reported.

## Structure
- Package latency_pipe_sched_pkg holds:
  - state enum: IDLE, CLR, RUN, DRAIN
  - LAT_W helper function
  - lane-slice helper for cfg_lat/lat_o
- One sub-module, pipe_vld_tracker:
  - Holds the MAX_PIPE_STAGE-bit shift register and per-lane tap muxes.
  - Interface: clk, rst_n, clr, in_vld, lat vector → lane_vld.
- Top level holds the FSM, cfg capture/clamp/max, and the inflight counter.

## Test plan
- Reset → cfg_ready=1, issue_ready=0, all valids 0. Then cfg lanes {1,2,3,4} → clr_o pulse one cycle later, issue_ready one cycle after that.
- Config {0,1,2,4}, issue at cycles 10 and 11:
  - lane_vld[0] at cycles 10 and 11.
  - lane_vld[3] and out_valid at cycles 14 and 15.
  - inflight peaks at 2.
- Continuous issue with lat_max=4, then cfg_valid at cycle 20:
  - issue_ready drops at cycle 20.
  - cfg_ready rises only after the final out_valid at cycle 23.
  - No token is lost.
- cfg lane value 7 with MAX_PIPE_STAGE=4 → lat_o lane=4 and cfg_err=1. Next config with all lanes legal → cfg_err=0.
- flush with 3 tokens in flight → clr_o=1, no further lane_vld/out_valid, state IDLE, busy=0 next cycle.
- rst_n asserted mid-DRAIN → all outputs return to their reset values immediately.
